// File: rtl/int_freelist.sv
// int_freelist: physical register free list for the integer rename stage.
//
// A FL_DEPTH-entry circular buffer holds the free physical register indices.
// Rename pops from the speculative head and commit frees at the tail. A
// separate architectural head and count advance only at commit, so a squash
// rolls the speculative head and count back to them in a single cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_alloc_req         per-lane request for a new destination register
//   o_can_alloc         at least ALLOC_WIDTH free entries are available
//   o_alloc_iprIdx      allocated index per lane (compacted over requesting lanes)
//   i_alloc_fire        rename accepted this cycle; consumes the allocation
//   i_commit_dst_vld    committing instructions that wrote an int destination
//   i_free_vld          old mappings released at commit
//   i_free_iprIdx       released indices (p0 is never enqueued)
//   i_squash            pipeline flush; restore speculative state
//   o_free_count        speculative free count

`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

// Invariant checker for the free list bookkeeping.
module int_freelist_chk #(
    parameter int FL_DEPTH = 48,
    parameter int CNT_W    = 6
) (
    input logic             clk,
    input logic             rst,
    input logic             alloc_fire,
    input logic             can_alloc,
    input logic [CNT_W-1:0] spec_count,
    input logic [CNT_W-1:0] arch_count,
    input logic [CNT_W-1:0] nfree,
    input logic [CNT_W-1:0] nalloc_do,
    input logic [CNT_W-1:0] ncommit
);
    // Rename must not fire while the list reports it cannot allocate.
    a_fire_ok: assert property (@(posedge clk) disable iff (rst)
        !(alloc_fire && !can_alloc));
    // Overflowing the list means some index was freed twice.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (int'(spec_count) + int'(nfree) - int'(nalloc_do)) <= FL_DEPTH);
    // Commit can never retire more destinations than were handed out.
    a_arch_no_underflow: assert property (@(posedge clk) disable iff (rst)
        (int'(arch_count) + int'(nfree)) >= int'(ncommit));
    // Speculative state always runs ahead of the committed state.
    a_spec_le_arch: assert property (@(posedge clk) disable iff (rst)
        spec_count <= arch_count);
endmodule

module int_freelist #(
    parameter int SIZE         = 80,
    parameter int ARCH_NUM     = 32,
    parameter int ALLOC_WIDTH  = `RENAME_WIDTH,
    parameter int COMMIT_WIDTH = `COMMIT_WIDTH,
    localparam int FL_DEPTH    = SIZE - ARCH_NUM,
    localparam int IDX_W       = $clog2(SIZE),
    localparam int PTR_W       = $clog2(FL_DEPTH),
    localparam int CNT_W       = $clog2(FL_DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ALLOC_WIDTH-1:0]              i_alloc_req,
    output logic                                o_can_alloc,
    output logic [ALLOC_WIDTH-1:0][IDX_W-1:0]   o_alloc_iprIdx,
    input  logic                                i_alloc_fire,
    input  logic [COMMIT_WIDTH-1:0]             i_commit_dst_vld,
    input  logic [COMMIT_WIDTH-1:0]             i_free_vld,
    input  logic [COMMIT_WIDTH-1:0][IDX_W-1:0]  i_free_iprIdx,
    input  logic                                i_squash,
    output logic [CNT_W-1:0]                    o_free_count
);

    // Modular pointer advance; the depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [CNT_W-1:0] n);
        logic [PTR_W:0] sum;
        sum = {1'b0, p} + (PTR_W+1)'(n);
        if (sum >= (PTR_W+1)'(FL_DEPTH)) begin
            return PTR_W'(sum - (PTR_W+1)'(FL_DEPTH));
        end else begin
            return PTR_W'(sum);
        end
    endfunction

    logic [IDX_W-1:0]  buf_r [FL_DEPTH];
    logic [PTR_W-1:0]  spec_head_r, arch_head_r, tail_r;
    logic [CNT_W-1:0]  spec_count_r, arch_count_r;

    logic [CNT_W-1:0]  nalloc_s, ncommit_s, nfree_s, nalloc_do_s;
    logic [CNT_W-1:0]  alloc_off_s;
    logic [COMMIT_WIDTH-1:0]            free_ok_s;
    logic [COMMIT_WIDTH-1:0][PTR_W-1:0] free_ptr_s;
    logic              can_alloc_s, alloc_do_s;
    logic [PTR_W-1:0]  spec_head_n_s, arch_head_n_s, tail_n_s;
    logic [CNT_W-1:0]  spec_count_n_s, arch_count_n_s;

    assign nalloc_s  = CNT_W'($countones(i_alloc_req));
    assign ncommit_s = CNT_W'($countones(i_commit_dst_vld));

    // Availability and count outputs are forced low while reset is held.
    assign can_alloc_s  = !rst && (spec_count_r >= CNT_W'(ALLOC_WIDTH));
    assign o_can_alloc  = can_alloc_s;
    assign o_free_count = rst ? '0 : spec_count_r;
    assign alloc_do_s   = i_alloc_fire && can_alloc_s && !i_squash;
    assign nalloc_do_s  = alloc_do_s ? nalloc_s : '0;

    // Compacting allocation: the k-th requesting lane reads spec_head+k.
    always_comb begin
        alloc_off_s    = '0;
        o_alloc_iprIdx = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            o_alloc_iprIdx[i] = buf_r[ptr_add(spec_head_r, alloc_off_s)];
            if (i_alloc_req[i]) begin
                alloc_off_s = alloc_off_s + CNT_W'(1);
            end else begin
                alloc_off_s = alloc_off_s;
            end
        end
    end

    // Compacting free: valid non-zero indices go to tail, tail+1, ... in lane order.
    always_comb begin
        nfree_s    = '0;
        free_ok_s  = '0;
        free_ptr_s = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            free_ok_s[j]  = i_free_vld[j] && (i_free_iprIdx[j] != IDX_W'(0));
            free_ptr_s[j] = ptr_add(tail_r, nfree_s);
            if (free_ok_s[j]) begin
                nfree_s = nfree_s + CNT_W'(1);
            end else begin
                nfree_s = nfree_s;
            end
        end
    end

    // Next-state pointers and counts; a squash copies the post-commit arch state.
    always_comb begin
        arch_head_n_s  = ptr_add(arch_head_r, ncommit_s);
        arch_count_n_s = arch_count_r + nfree_s - ncommit_s;
        tail_n_s       = ptr_add(tail_r, nfree_s);
        spec_head_n_s  = spec_head_r;
        spec_count_n_s = spec_count_r + nfree_s;
        if (i_squash) begin
            spec_head_n_s  = arch_head_n_s;
            spec_count_n_s = arch_count_n_s;
        end else if (alloc_do_s) begin
            spec_head_n_s  = ptr_add(spec_head_r, nalloc_s);
            spec_count_n_s = spec_count_r + nfree_s - nalloc_s;
        end else begin
            spec_head_n_s  = spec_head_r;
            spec_count_n_s = spec_count_r + nfree_s;
        end
    end

    // State update; reset reloads the buffer with the unmapped registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                buf_r[k] <= IDX_W'(ARCH_NUM + k);
            end
            spec_head_r  <= '0;
            arch_head_r  <= '0;
            tail_r       <= '0;
            spec_count_r <= CNT_W'(FL_DEPTH);
            arch_count_r <= CNT_W'(FL_DEPTH);
        end else begin
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (free_ok_s[j]) begin
                    buf_r[free_ptr_s[j]] <= i_free_iprIdx[j];
                end
            end
            spec_head_r  <= spec_head_n_s;
            arch_head_r  <= arch_head_n_s;
            tail_r       <= tail_n_s;
            spec_count_r <= spec_count_n_s;
            arch_count_r <= arch_count_n_s;
        end
    end

    int_freelist_chk #(.FL_DEPTH(FL_DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .alloc_fire (i_alloc_fire),
        .can_alloc  (can_alloc_s),
        .spec_count (spec_count_r),
        .arch_count (arch_count_r),
        .nfree      (nfree_s),
        .nalloc_do  (nalloc_do_s),
        .ncommit    (ncommit_s)
    );

endmodule

// File: tb/tb_int_freelist.sv
// Scoreboard bench for int_freelist: the driver pushes the hand-computed
// expected outputs for each cycle, the monitor pops and compares them on the
// falling edge.
module tb_int_freelist;
    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            i_alloc_req;
    logic                  o_can_alloc;
    logic [3:0][6:0]       o_alloc_iprIdx;
    logic                  i_alloc_fire;
    logic [3:0]            i_commit_dst_vld;
    logic [3:0]            i_free_vld;
    logic [3:0][6:0]       i_free_iprIdx;
    logic                  i_squash;
    logic [5:0]            o_free_count;

    typedef struct packed {
        logic [3:0]      mask;
        logic [3:0][6:0] idx;
        logic            can;
        logic [5:0]      cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_freelist dut (
        .clk              (clk),
        .rst              (rst),
        .i_alloc_req      (i_alloc_req),
        .o_can_alloc      (o_can_alloc),
        .o_alloc_iprIdx   (o_alloc_iprIdx),
        .i_alloc_fire     (i_alloc_fire),
        .i_commit_dst_vld (i_commit_dst_vld),
        .i_free_vld       (i_free_vld),
        .i_free_iprIdx    (i_free_iprIdx),
        .i_squash         (i_squash),
        .o_free_count     (o_free_count)
    );

    function automatic logic [3:0][6:0] lanes(input int a, input int b, input int c, input int d);
        logic [3:0][6:0] v;
        v[0] = 7'(a); v[1] = 7'(b); v[2] = 7'(c); v[3] = 7'(d);
        return v;
    endfunction

    // Drive one cycle of stimulus and record the outputs expected during it.
    task automatic step(input logic r, input logic [3:0] req, input logic fire,
                        input logic [3:0] cdst, input logic [3:0] fvld,
                        input logic [3:0][6:0] fidx, input logic sq,
                        input logic [3:0] emask, input logic [3:0][6:0] eidx,
                        input logic ecan, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; i_alloc_req = req; i_alloc_fire = fire;
        i_commit_dst_vld = cdst; i_free_vld = fvld; i_free_iprIdx = fidx;
        i_squash = sq;
        e.mask = emask; e.idx = eidx; e.can = ecan; e.cnt = 6'(ecnt);
        sb.push_back(e);
    endtask

    // Monitor: compare the oldest expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (o_can_alloc !== e.can) begin
                errors++;
                $display("FAIL can_alloc got %0b want %0b at %0t", o_can_alloc, e.can, $time);
            end
            checks++;
            if (o_free_count !== e.cnt) begin
                errors++;
                $display("FAIL free_count got %0d want %0d at %0t", o_free_count, e.cnt, $time);
            end
            for (int i = 0; i < 4; i++) begin
                if (e.mask[i]) begin
                    checks++;
                    if (o_alloc_iprIdx[i] !== e.idx[i]) begin
                        errors++;
                        $display("FAIL alloc_idx lane%0d got %0d want %0d at %0t",
                                 i, o_alloc_iprIdx[i], e.idx[i], $time);
                    end
                end
            end
        end
    end

    // Hard time limit in case the stimulus process ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout reached with %0d expectations pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0][6:0] z;
        z = lanes(0, 0, 0, 0);
        rst = 1'b1; i_alloc_req = '0; i_alloc_fire = 1'b0; i_commit_dst_vld = '0;
        i_free_vld = '0; i_free_iprIdx = '0; i_squash = 1'b0;

        // Reset image, then drain all 48 entries four at a time.
        step(1, 4'b0000, 0, 4'b0000, 4'b0000, z, 0, 4'b0000, z, 0, 0);
        for (int k = 0; k < 12; k++)
            step(0, 4'b1111, 1, 4'b0000, 4'b0000, z, 0, 4'b1111,
                 lanes(32+4*k, 33+4*k, 34+4*k, 35+4*k), 1, 48-4*k);
        step(0, 4'b1111, 0, 4'b0000, 4'b0000, z, 0, 4'b0000, z, 0, 0);
        // Free {5,0,7,9}: p0 dropped, three entries; one more makes four.
        step(0, 4'b0000, 0, 4'b0111, 4'b1111, lanes(5, 0, 7, 9), 0, 4'b0000, z, 0, 0);
        step(0, 4'b0000, 0, 4'b0001, 4'b0001, lanes(11, 0, 0, 0), 0, 4'b0000, z, 0, 3);
        step(0, 4'b1111, 0, 4'b0000, 4'b0000, z, 0, 4'b1111, lanes(5, 7, 9, 11), 1, 4);

        // Sparse request 1010 compacts onto lanes 1 and 3.
        step(1, 4'b0000, 0, 4'b0000, 4'b0000, z, 0, 4'b0000, z, 0, 0);
        step(0, 4'b1010, 1, 4'b0000, 4'b0000, z, 0, 4'b1010, lanes(0, 32, 0, 33), 1, 48);
        step(0, 4'b0001, 0, 4'b0000, 4'b0000, z, 0, 4'b0001, lanes(34, 0, 0, 0), 1, 46);

        // Allocate 8, then squash with a same-cycle commit of 4 and a dropped alloc.
        step(1, 4'b0000, 0, 4'b0000, 4'b0000, z, 0, 4'b0000, z, 0, 0);
        step(0, 4'b1111, 1, 4'b0000, 4'b0000, z, 0, 4'b1111, lanes(32, 33, 34, 35), 1, 48);
        step(0, 4'b1111, 1, 4'b0000, 4'b0000, z, 0, 4'b1111, lanes(36, 37, 38, 39), 1, 44);
        step(0, 4'b1111, 1, 4'b1111, 4'b0000, z, 1, 4'b1111, lanes(40, 41, 42, 43), 1, 40);
        step(0, 4'b1111, 0, 4'b0000, 4'b0000, z, 0, 4'b1111, lanes(36, 37, 38, 39), 1, 44);

        // Wrap: allocate 44, free 1..8 at the start of the buffer, then allocate 12.
        step(1, 4'b0000, 0, 4'b0000, 4'b0000, z, 0, 4'b0000, z, 0, 0);
        for (int k = 0; k < 11; k++)
            step(0, 4'b1111, 1, 4'b0000, 4'b0000, z, 0, 4'b1111,
                 lanes(32+4*k, 33+4*k, 34+4*k, 35+4*k), 1, 48-4*k);
        step(0, 4'b1111, 0, 4'b1111, 4'b1111, lanes(1, 2, 3, 4), 0, 4'b1111, lanes(76, 77, 78, 79), 1, 4);
        step(0, 4'b1111, 0, 4'b1111, 4'b1111, lanes(5, 6, 7, 8), 0, 4'b1111, lanes(76, 77, 78, 79), 1, 8);
        step(0, 4'b1111, 1, 4'b0000, 4'b0000, z, 0, 4'b1111, lanes(76, 77, 78, 79), 1, 12);
        step(0, 4'b1111, 1, 4'b0000, 4'b0000, z, 0, 4'b1111, lanes(1, 2, 3, 4), 1, 8);
        step(0, 4'b1111, 1, 4'b0000, 4'b0000, z, 0, 4'b1111, lanes(5, 6, 7, 8), 1, 4);
        step(0, 4'b0000, 0, 4'b0000, 4'b0000, z, 0, 4'b0000, z, 0, 0);

        // Reset mid-stream with a pending free: the free is discarded.
        step(1, 4'b0000, 0, 4'b0000, 4'b1111, lanes(10, 11, 12, 13), 0, 4'b0000, z, 0, 0);
        step(0, 4'b1111, 0, 4'b0000, 4'b0000, z, 0, 4'b1111, lanes(32, 33, 34, 35), 1, 48);

        @(posedge clk);
        #1;
        i_alloc_req = '0; i_free_vld = '0; i_commit_dst_vld = '0;
        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_freelist.md
Name: int_freelist

Overview:
Physical register free list for the integer rename stage. Hands out free physical register indices to rename each cycle and receives released indices from commit.
The indices it hands out are the ones rename marks not-ready in the integer regfile via i_notready_mark / i_notready_iprIdx.
Keeps a speculative head and an architectural (committed) head so a squash restores the free list in one cycle.

Parameters:
SIZE, 80, number of physical integer registers; index width $clog2(SIZE)=7
ARCH_NUM, 32, architectural registers; p0..p31 are mapped at reset and not in the list
ALLOC_WIDTH, `RENAME_WIDTH, allocation lanes per cycle
COMMIT_WIDTH, `COMMIT_WIDTH, commit/free lanes per cycle
FL_DEPTH, SIZE-ARCH_NUM (48), free list capacity; derived, not overridable

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_alloc_req  in  ALLOC_WIDTH  per-lane request for a new destination register
o_can_alloc  out  1  spec_count >= ALLOC_WIDTH; rename stalls when low
o_alloc_iprIdx  out  iprIdx_t[ALLOC_WIDTH]  allocated index per lane, valid when its lane requests and o_can_alloc=1
i_alloc_fire  in  1  rename accepted this cycle; commits the allocation
i_commit_dst_vld  in  COMMIT_WIDTH  committing instr writes an int dest; advances the arch head
i_free_vld  in  COMMIT_WIDTH  old mapping released at commit
i_free_iprIdx  in  iprIdx_t[COMMIT_WIDTH]  released indices
i_squash  in  1  pipeline flush; restore the speculative head
o_free_count  out  $clog2(FL_DEPTH+1)  spec_count, for perf counters and debug

Behaviour:
- Storage: FL_DEPTH-entry circular buffer of iprIdx_t.
- Pointers: spec_head, arch_head, tail, each 0..FL_DEPTH-1.
- Counts: spec_count and arch_count, 0..FL_DEPTH.
- Pointer advance is modular: p+n >= FL_DEPTH ? p+n-FL_DEPTH : p+n. Non-power-of-2 depth is handled explicitly.
- Reset: buffer[k]=ARCH_NUM+k; all pointers 0; spec_count=arch_count=FL_DEPTH.
- Outputs while rst=1: o_can_alloc=0, o_free_count=0.
- First cycle after reset: o_can_alloc=1, o_alloc_iprIdx[i]=ARCH_NUM+i, o_free_count=48.
- Allocation is combinational and compacting: requesting lanes, in ascending order, get buffer[spec_head+0], [+1], ... Non-requesting lanes output don't-care.
- Alloc update on the next edge, when i_alloc_fire && o_can_alloc && !i_squash:
  - spec_head += popcount(i_alloc_req)
  - spec_count -= popcount(i_alloc_req)
- i_alloc_fire with o_can_alloc=0 is ignored; assert it never happens.
- Free update on the next edge: lanes with i_free_vld=1 and index != 0 are written at tail, tail+1, ... in lane order.
  - tail += nfree
  - spec_count += nfree; arch_count += nfree
  - p0 is never enqueued (HAS_ZERO).
- Freed indices become allocable the cycle after the free; there is no same-cycle bypass.
- Commit update:
  - arch_head += popcount(i_commit_dst_vld)
  - arch_count -= popcount(i_commit_dst_vld)
- Squash (i_squash=1):
  - Allocation that cycle is dropped.
  - Same-cycle commit and free are still applied.
  - Next state: spec_head = new arch_head, spec_count = new arch_count.
- Simultaneous alloc + free in a non-squash cycle: spec_count += nfree - nalloc. The buffer write and head read never collide, because spec_count < FL_DEPTH whenever frees occur.
- Assertions:
  - spec_count + nfree - nalloc <= FL_DEPTH (overflow means a double free).
  - arch_count never underflows.
  - spec_count <= arch_count.
- Reset mid-operation: everything returns to the reset image in one cycle; in-flight frees are discarded.

Test Plan:
- Reset, then alloc_req=4'b1111 with fire for 12 cycles -> indices 32..79 in order; o_can_alloc=0 after cycle 12; o_free_count=0.
- alloc_req=4'b1010 from reset -> lane1=32, lane3=33; o_free_count 48->46.
- Allocate 8, commit 4 dests, squash -> next o_alloc_iprIdx[0]=36; o_free_count=44.
- Drain to 0; free lanes {5,0,7,9} -> tail gets 5,7,9 (p0 dropped); count=3 next cycle; o_can_alloc stays 0 while ALLOC_WIDTH=4.
- Wrap: alloc 44, free 8 (indices 1..8), then alloc 12 -> values 76..79 then 1..8; pointers wrap at 48 with no gap.
- Assert rst mid-stream with pending free -> next cycle count=48, index 32 on lane0.
